// File: rtl/multiexp_feeder_pkg.sv
// Shared types and width helpers for the multiexp input feeder.
// Default widths describe a bn128 Jacobian point plus one scalar.
package multiexp_feeder_pkg;

    localparam int FE_BITS_DEF = 256;
    localparam int FP_BITS_DEF = 3 * 256;  // x, y, z in Montgomery form

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_DRAIN,
        S_REPLAY
    } feeder_state_t;

    function automatic int dat_in0(input int fp_bits, input int fe_bits);
        return fp_bits + fe_bits;
    endfunction

    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/multiexp_feeder_ram.sv
// Pair store for the feeder: simple dual-port, write from the load side,
// one-cycle registered read for the replay side.
module multiexp_feeder_ram
    import multiexp_feeder_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 8,
    localparam int AW    = addr_bits(DEPTH)
) (
    input  logic             i_clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/multiexp_feeder.sv
// Loads up to NUM_IN {point, scalar} pairs once and replays them KEY_BITS
// times as single-beat packets (ctl = pair index) into the multiexp core.
//   state        | meaning
//   S_IDLE       | empty, waiting for the first load beat (stored at index 0)
//   S_LOAD       | storing load beats at index cnt until eop or store full
//   S_LOAD_DRAIN | store full, dropping beats (sets ovf) until eop
//   S_REPLAY     | streaming passes out, load side back-pressured
module multiexp_feeder
    import multiexp_feeder_pkg::*;
#(
    parameter int  NUM_IN   = 4,
    parameter int  KEY_BITS = 256,
    parameter int  CTL_BITS = 8,
    parameter int  FP_BITS  = FP_BITS_DEF,
    parameter int  FE_BITS  = FE_BITS_DEF,
    localparam int DAT_W    = dat_in0(FP_BITS, FE_BITS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_ld_val,
    input  logic [DAT_W-1:0]    i_ld_dat,
    input  logic [CTL_BITS-1:0] i_ld_ctl,
    input  logic                i_ld_sop,
    input  logic                i_ld_eop,
    output logic                o_ld_rdy,
    output logic                o_pnt_scl_val,
    output logic [DAT_W-1:0]    o_pnt_scl_dat,
    output logic [CTL_BITS-1:0] o_pnt_scl_ctl,
    output logic                o_pnt_scl_sop,
    output logic                o_pnt_scl_eop,
    output logic                o_pnt_scl_mod,
    output logic                o_pnt_scl_err,
    input  logic                i_pnt_scl_rdy,
    output logic                o_busy,
    output logic                o_ovf
);

    localparam int AW = addr_bits(NUM_IN);
    localparam int CW = $clog2(NUM_IN + 1);
    localparam int PW = $clog2(KEY_BITS) + 1;

    feeder_state_t       state, state_nxt;
    logic [CW-1:0]       cnt, cnt_inc, n_pairs;
    logic                wr_en, set_ovf, last_pop;
    logic [AW-1:0]       rd_idx;
    logic [PW-1:0]       pass;
    logic                rd_done, rd_en, rd_pending;
    logic [CTL_BITS-1:0] rd_ctl;
    logic [DAT_W-1:0]    ram_dat;
    logic [DAT_W-1:0]    skid_dat [2];
    logic [CTL_BITS-1:0] skid_ctl [2];
    logic [1:0]          skid_cnt;
    logic [2:0]          occ;
    logic                pop;
    logic                unused_ld;

    // Load-side ctl/sop carry no meaning for this block.
    assign unused_ld = ^{i_ld_ctl, i_ld_sop};
    assign cnt_inc   = cnt + CW'(1);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_ld_rdy  = 1'b0;
        wr_en     = 1'b0;
        set_ovf   = 1'b0;
        case (state)
            S_IDLE, S_LOAD: begin
                o_ld_rdy = i_rst;
                if (i_ld_val && i_rst) begin
                    wr_en = 1'b1;
                    if (i_ld_eop) begin
                        state_nxt = S_REPLAY;
                    end else if (cnt_inc == CW'(NUM_IN)) begin
                        state_nxt = S_LOAD_DRAIN;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD_DRAIN: begin
                o_ld_rdy = i_rst;
                if (i_ld_val && i_rst) begin
                    set_ovf = 1'b1;
                    if (i_ld_eop) begin
                        state_nxt = S_REPLAY;
                    end
                end
            end
            S_REPLAY: begin
                if (last_pop) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt     <= '0;
            n_pairs <= '0;
            o_ovf   <= 1'b0;
        end else begin
            if (set_ovf) begin
                o_ovf <= 1'b1;
            end
            if (state == S_REPLAY && state_nxt == S_IDLE) begin
                cnt <= '0;
            end else if (wr_en) begin
                cnt <= cnt_inc;
            end
            if (state != S_REPLAY && state_nxt == S_REPLAY) begin
                n_pairs <= wr_en ? cnt_inc : cnt;
            end
        end
    end

    // Reads are issued only when the skid buffer has room for the data
    // already in flight from the registered RAM, so stalls never drop a beat.
    assign pop      = o_pnt_scl_val && i_pnt_scl_rdy;
    assign occ      = {1'b0, skid_cnt} + {2'b00, rd_pending};
    assign rd_en    = (state == S_REPLAY) && !rd_done && ((occ != 3'd2) || pop);
    assign last_pop = pop && rd_done && !rd_pending && (skid_cnt == 2'd1);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rd_idx     <= '0;
            pass       <= '0;
            rd_done    <= 1'b0;
            rd_pending <= 1'b0;
            rd_ctl     <= '0;
        end else begin
            rd_pending <= rd_en;
            if (rd_en) begin
                rd_ctl <= CTL_BITS'(rd_idx);
            end
            if (state != S_REPLAY) begin
                rd_idx  <= '0;
                pass    <= '0;
                rd_done <= 1'b0;
            end else if (rd_en) begin
                if (CW'(rd_idx) == n_pairs - CW'(1)) begin
                    rd_idx <= '0;
                    if (pass == PW'(KEY_BITS - 1)) begin
                        rd_done <= 1'b1;
                    end else begin
                        pass <= pass + PW'(1);
                    end
                end else begin
                    rd_idx <= rd_idx + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            skid_cnt    <= '0;
            skid_dat[0] <= '0;
            skid_dat[1] <= '0;
            skid_ctl[0] <= '0;
            skid_ctl[1] <= '0;
        end else begin
            case ({rd_pending, pop})
                2'b10: begin
                    skid_dat[skid_cnt[0]] <= ram_dat;
                    skid_ctl[skid_cnt[0]] <= rd_ctl;
                    skid_cnt              <= skid_cnt + 2'd1;
                end
                2'b01: begin
                    skid_dat[0] <= skid_dat[1];
                    skid_ctl[0] <= skid_ctl[1];
                    skid_cnt    <= skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid_dat[0] <= ram_dat;
                        skid_ctl[0] <= rd_ctl;
                    end else begin
                        skid_dat[0] <= skid_dat[1];
                        skid_ctl[0] <= skid_ctl[1];
                        skid_dat[1] <= ram_dat;
                        skid_ctl[1] <= rd_ctl;
                    end
                end
                default: ;
            endcase
        end
    end

    multiexp_feeder_ram #(
        .DEPTH (NUM_IN),
        .WIDTH (DAT_W)
    ) u_ram (
        .i_clk   (i_clk),
        .wr_en   (wr_en),
        .wr_addr (cnt[AW-1:0]),
        .wr_dat  (i_ld_dat),
        .rd_en   (rd_en),
        .rd_addr (rd_idx),
        .rd_dat  (ram_dat)
    );

    assign o_pnt_scl_val = (skid_cnt != 2'd0);
    assign o_pnt_scl_dat = skid_dat[0];
    assign o_pnt_scl_ctl = skid_ctl[0];
    assign o_pnt_scl_sop = o_pnt_scl_val;
    assign o_pnt_scl_eop = o_pnt_scl_val;
    assign o_pnt_scl_mod = 1'b0;
    assign o_pnt_scl_err = 1'b0;
    assign o_busy        = (state != S_IDLE);

endmodule

// File: tb/tb_multiexp_feeder.sv
// Self-checking bench for multiexp_feeder: scenario table plus a mid-replay
// reset sequence, with a queue scoreboard checking every replay beat.
module tb_multiexp_feeder;
    import multiexp_feeder_pkg::*;

    localparam int NUM_IN   = 4;
    localparam int KEY_BITS = 256;
    localparam int CTL_BITS = 8;
    localparam int DW       = dat_in0(FP_BITS_DEF, FE_BITS_DEF);

    typedef struct {
        logic [CTL_BITS-1:0] ctl;
        logic [DW-1:0]       dat;
    } beat_t;

    typedef struct {
        string name;
        int    n_load;
        bit    rand_rdy;
        int    exp_n;
        bit    exp_ovf;
    } vec_t;

    logic                clk;
    logic                rst_n;
    logic                ld_val, ld_sop, ld_eop, ld_rdy;
    logic [DW-1:0]       ld_dat;
    logic [CTL_BITS-1:0] ld_ctl;
    logic                out_val, out_sop, out_eop, out_mod, out_err, out_rdy;
    logic [DW-1:0]       out_dat;
    logic [CTL_BITS-1:0] out_ctl;
    logic                busy, ovf;

    int    total = 0;
    int    bad = 0;
    int    beats_seen = 0;
    bit    mon_en = 0;
    bit    rand_rdy = 0;
    bit    prev_stall = 0;
    logic [DW-1:0]       prev_dat;
    logic [CTL_BITS-1:0] prev_ctl;
    beat_t exp_q[$];
    logic [DW-1:0] pairs [8];
    vec_t  vecs [5];

    multiexp_feeder #(
        .NUM_IN   (NUM_IN),
        .KEY_BITS (KEY_BITS),
        .CTL_BITS (CTL_BITS)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_ld_val      (ld_val),
        .i_ld_dat      (ld_dat),
        .i_ld_ctl      (ld_ctl),
        .i_ld_sop      (ld_sop),
        .i_ld_eop      (ld_eop),
        .o_ld_rdy      (ld_rdy),
        .o_pnt_scl_val (out_val),
        .o_pnt_scl_dat (out_dat),
        .o_pnt_scl_ctl (out_ctl),
        .o_pnt_scl_sop (out_sop),
        .o_pnt_scl_eop (out_eop),
        .o_pnt_scl_mod (out_mod),
        .o_pnt_scl_err (out_err),
        .i_pnt_scl_rdy (out_rdy),
        .o_busy        (busy),
        .o_ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard and hold-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        beat_t e;
        if (mon_en) begin
            if (prev_stall) begin
                total++;
                if (!(out_val && out_dat == prev_dat && out_ctl == prev_ctl)) begin
                    bad++;
                    $display("FAIL hold_stable val=%0b ctl=%0d required_ctl=%0d", out_val, out_ctl, prev_ctl);
                end
            end
            prev_stall = out_val && !out_rdy;
            prev_dat   = out_dat;
            prev_ctl   = out_ctl;
            if (out_val && out_rdy) begin
                total++;
                beats_seen++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_beat ctl=%0d dat_lo=%0h required=none", out_ctl, out_dat[63:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (out_ctl !== e.ctl || out_dat !== e.dat || out_sop !== 1'b1 ||
                        out_eop !== 1'b1 || out_mod !== 1'b0 || out_err !== 1'b0) begin
                        bad++;
                        $display("FAIL beat_%0d ctl=%0d dat_lo=%0h sop=%0b eop=%0b required ctl=%0d dat_lo=%0h",
                                 beats_seen - 1, out_ctl, out_dat[63:0], out_sop, out_eop, e.ctl, e.dat[63:0]);
                    end
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic gen(output logic [DW-1:0] d);
        for (int k = 0; k < DW / 32; k++) begin
            d[k*32 +: 32] = $urandom();
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        ld_val = 1'b0;
        ld_eop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_val", out_val, 0);
        chk("rst_sop_eop", {out_sop, out_eop}, 0);
        chk("rst_ctl", out_ctl, 0);
        chk("rst_ld_rdy", ld_rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        exp_q.delete();
        beats_seen = 0;
        mon_en = 1'b1;
        #1;
        chk("idle_ld_rdy", ld_rdy, 1);
    endtask

    task automatic load_beat(input logic [DW-1:0] d, input logic eop);
        int w;
        ld_val = 1'b1;
        ld_dat = d;
        ld_eop = eop;
        w = 0;
        @(negedge clk);
        while (!ld_rdy && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!ld_rdy) begin
            total++;
            bad++;
            $display("FAIL load_rdy_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1;
        ld_val = 1'b0;
        ld_eop = 1'b0;
    endtask

    task automatic push_expected(input int n);
        beat_t b;
        for (int p = 0; p < KEY_BITS; p++) begin
            for (int i = 0; i < n; i++) begin
                b.ctl = CTL_BITS'(i);
                b.dat = pairs[i];
                exp_q.push_back(b);
            end
        end
    endtask

    // Called #1 after the final load transfer edge.
    task automatic check_latency();
        chk("val_t0", out_val, 0);
        @(posedge clk);
        #1;
        chk("val_t1", out_val, 0);
        @(posedge clk);
        #1;
        chk("val_t2", out_val, 1);
        chk("busy_replay", busy, 1);
        chk("ld_rdy_replay", ld_rdy, 0);
    endtask

    task automatic wait_done(input int exp_beats);
        int c;
        c = 0;
        while (beats_seen < exp_beats && c < 8000) begin
            @(posedge clk);
            c++;
        end
        if (beats_seen < exp_beats) begin
            total++;
            bad++;
            $display("FAIL replay_timeout beats=%0d required=%0d", beats_seen, exp_beats);
        end
        #1;
        chk("busy_end", busy, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("beat_count", beats_seen, exp_beats);
        chk("queue_empty", exp_q.size(), 0);
        chk("val_idle", out_val, 0);
        chk("ld_rdy_after", ld_rdy, 1);
    endtask

    task automatic run_vec(input vec_t v);
        do_reset();
        rand_rdy = v.rand_rdy;
        for (int b = 0; b < v.n_load; b++) begin
            gen(pairs[b]);
            load_beat(pairs[b], b == v.n_load - 1);
        end
        push_expected(v.exp_n);
        check_latency();
        wait_done(v.exp_n * KEY_BITS);
        chk({"ovf_", v.name}, ovf, v.exp_ovf);
        rand_rdy = 1'b0;
    endtask

    task automatic reset_mid_replay();
        int c;
        do_reset();
        for (int b = 0; b < 4; b++) begin
            gen(pairs[b]);
            load_beat(pairs[b], b == 3);
        end
        push_expected(4);
        c = 0;
        while (beats_seen < 100 && c < 1000) begin
            @(posedge clk);
            c++;
        end
        chk("pre_reset_beats", beats_seen, 100);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_val", out_val, 0);
        chk("mid_rst_ld_rdy", ld_rdy, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        beats_seen = 0;
        mon_en = 1'b1;
        chk("post_rst_val", out_val, 0);
        for (int b = 0; b < 2; b++) begin
            gen(pairs[b]);
            load_beat(pairs[b], b == 1);
        end
        push_expected(2);
        check_latency();
        wait_done(2 * KEY_BITS);
    endtask

    initial begin
        vecs[0] = '{"full4",    4, 1'b0, 4, 1'b0};
        vecs[1] = '{"three",    3, 1'b0, 3, 1'b0};
        vecs[2] = '{"overflow", 6, 1'b0, 4, 1'b1};
        vecs[3] = '{"rand_rdy", 4, 1'b1, 4, 1'b0};
        vecs[4] = '{"single",   1, 1'b0, 1, 1'b0};

        rst_n  = 1'b0;
        ld_val = 1'b0;
        ld_sop = 1'b0;
        ld_eop = 1'b0;
        ld_ctl = '0;
        ld_dat = '0;
        repeat (3) @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            run_vec(vecs[v]);
        end
        reset_mid_replay();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
